parking_gate_ctrl: RTL and testbench

Parametrised parking-entrance gate controller, next generation of the single-lane PIN gate FSM. It gates entry on a strobed PIN of configurable width with a configurable attempt limit. It detects tailgating (both gate sensors active) and blocks until a correct PIN is entered. It also tracks lot occupancy against a configurable capacity, refusing entry when the lot is full.

---
 rtl/parking_pkg.sv | 13 +
 rtl/occupancy_counter.sv | 28 ++
 rtl/parking_gate_ctrl.sv | 139 +++++++++++++
 tb/tb_parking_gate_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking entrance gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PIN = 2'd1,
    OPEN     = 2'd2,
    BLOCK    = 2'd3
  } gate_state_e;

  localparam logic [7:0] DEFAULT_CORRECT_PIN = 8'h49;

endpackage

// File: rtl/occupancy_counter.sv
// Up/down counter saturating at 0 and MAX; a simultaneous inc and dec cancel.
module occupancy_counter #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (inc && !dec && r_count != CW'(MAX))
      r_count <= r_count + CW'(1);
    else if (dec && !inc && r_count != '0)
      r_count <= r_count - CW'(1);
  end

  assign count = r_count;
  assign full  = (r_count == CW'(MAX));

endmodule

// File: rtl/parking_gate_ctrl.sv
// PIN-gated parking entrance with tailgate block and lot occupancy tracking.
// Optional WAIT_PIN abandon timer enabled by defining PARKING_PIN_TIMEOUT_EN.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int               PIN_W        = 8,
  parameter logic [PIN_W-1:0] CORRECT_PIN  = PIN_W'(DEFAULT_CORRECT_PIN),
  parameter int               MAX_ATTEMPTS = 3,
  parameter int               CAPACITY     = 4,
  parameter int               PIN_TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sensor_entrance,
  input  logic                         sensor_exit,
  input  logic                         sensor_depart,
  input  logic                         pin_valid,
  input  logic [PIN_W-1:0]             input_password,
  output logic                         gate_open,
  output logic                         gate_close,
  output logic                         alarm_wrong_pin,
  output logic                         alarm_block,
  output logic                         lot_full,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

  if (MAX_ATTEMPTS < 1 || CAPACITY < 1 || PIN_TIMEOUT < 1) begin : g_bad_param
    $error("parking_gate_ctrl: MAX_ATTEMPTS, CAPACITY and PIN_TIMEOUT must be >= 1");
  end

  gate_state_e      r_state, w_state_nxt;
  logic [ATT_W-1:0] r_attempts, w_attempts_nxt, w_att_inc;
  logic             r_alarm, w_alarm_nxt;
  logic             w_tailgate, w_pin_ok, w_lot_full, w_occ_inc;

  assign w_tailgate = sensor_entrance && sensor_exit;
  assign w_pin_ok   = pin_valid && (input_password == CORRECT_PIN);
  assign w_occ_inc  = (r_state == OPEN) && sensor_exit;

`ifdef PARKING_PIN_TIMEOUT_EN
  localparam int TMR_W = $clog2(PIN_TIMEOUT + 1);
  logic [TMR_W-1:0] r_timer, w_timer_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_timer <= '0;
    else       r_timer <= w_timer_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_attempts <= '0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_attempts <= w_attempts_nxt;
      r_alarm    <= w_alarm_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_attempts_nxt = r_attempts;
    w_alarm_nxt    = r_alarm;
    w_att_inc      = r_attempts + ATT_W'(1);
`ifdef PARKING_PIN_TIMEOUT_EN
    w_timer_nxt    = r_timer;
`endif
    case (r_state)
      IDLE: begin
        if (w_tailgate)
          w_state_nxt = BLOCK;
        else if (sensor_entrance && !w_lot_full) begin
          w_state_nxt = WAIT_PIN;
`ifdef PARKING_PIN_TIMEOUT_EN
          w_timer_nxt = '0;
`endif
        end
      end
      WAIT_PIN: begin
        if (w_tailgate) begin
          w_state_nxt    = BLOCK;
          w_attempts_nxt = '0;
        end else if (w_pin_ok) begin
          w_state_nxt    = OPEN;
          w_attempts_nxt = '0;
          w_alarm_nxt    = 1'b0;
        end else if (pin_valid) begin
          // Alarm is sticky; the counter restarts so the next burst is counted afresh.
          if (w_att_inc == ATT_W'(MAX_ATTEMPTS)) begin
            w_alarm_nxt    = 1'b1;
            w_attempts_nxt = '0;
          end else begin
            w_attempts_nxt = w_att_inc;
          end
`ifdef PARKING_PIN_TIMEOUT_EN
          w_timer_nxt = '0;
        end else if (r_timer == TMR_W'(PIN_TIMEOUT - 1)) begin
          w_state_nxt    = IDLE;
          w_attempts_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
`endif
        end
      end
      OPEN: begin
        if (sensor_exit)
          w_state_nxt = sensor_entrance ? BLOCK : IDLE;
      end
      BLOCK: begin
        if (w_pin_ok) begin
          w_state_nxt = IDLE;
          w_alarm_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  occupancy_counter #(.MAX(CAPACITY), .CW(OCC_W)) u_occ (
    .clk   (clk),
    .reset (reset),
    .inc   (w_occ_inc),
    .dec   (sensor_depart),
    .count (occupancy),
    .full  (w_lot_full)
  );

  assign lot_full        = w_lot_full;
  assign gate_open       = (r_state == OPEN);
  assign gate_close      = ~gate_open;
  assign alarm_block     = (r_state == BLOCK);
  assign alarm_wrong_pin = r_alarm;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural gate model.
module tb_parking_gate_ctrl;

  localparam int          CAP  = 2;
  localparam int          MAXA = 3;
  localparam int          PTO  = 16;
  localparam logic [7:0]  PIN  = 8'h49;
  localparam int          M_IDLE = 0, M_WAIT = 1, M_OPEN = 2, M_BLOCK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sensor_entrance = 1'b0, sensor_exit = 1'b0, sensor_depart = 1'b0;
  logic       pin_valid = 1'b0;
  logic [7:0] input_password = 8'h00;
  logic       gate_open, gate_close, alarm_wrong_pin, alarm_block, lot_full;
  logic [1:0] occupancy;

  int n_vec = 0;
  int n_err = 0;

  parking_gate_ctrl #(.PIN_W(8), .CORRECT_PIN(PIN), .MAX_ATTEMPTS(MAXA),
                      .CAPACITY(CAP), .PIN_TIMEOUT(PTO)) dut (
    .clk(clk), .reset(reset), .sensor_entrance(sensor_entrance),
    .sensor_exit(sensor_exit), .sensor_depart(sensor_depart),
    .pin_valid(pin_valid), .input_password(input_password),
    .gate_open(gate_open), .gate_close(gate_close),
    .alarm_wrong_pin(alarm_wrong_pin), .alarm_block(alarm_block),
    .lot_full(lot_full), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference: where the vehicle/driver interaction is, how many cars are parked,
  // how many bad PINs in a row, how long we've waited for a PIN.
  int m_st = M_IDLE, m_occ = 0, m_bad = 0, m_wait = 0;
  bit m_alarm = 1'b0;

  always @(posedge clk) begin
    int  nocc;
    bit  ok, both;
    ok   = pin_valid && (input_password == PIN);
    both = sensor_entrance && sensor_exit;
    if (reset) begin
      m_st = M_IDLE; m_occ = 0; m_bad = 0; m_wait = 0; m_alarm = 1'b0;
    end else begin
      nocc = m_occ + ((m_st == M_OPEN && sensor_exit) ? 1 : 0) - (sensor_depart ? 1 : 0);
      if (nocc > CAP) nocc = CAP;
      if (nocc < 0)   nocc = 0;
      case (m_st)
        M_IDLE:
          if (both) m_st = M_BLOCK;
          else if (sensor_entrance && m_occ < CAP) begin m_st = M_WAIT; m_wait = 0; end
        M_WAIT:
          if (both) begin m_st = M_BLOCK; m_bad = 0; end
          else if (ok) begin m_st = M_OPEN; m_bad = 0; m_alarm = 1'b0; end
          else if (pin_valid) begin
            m_bad++; m_wait = 0;
            if (m_bad == MAXA) begin m_alarm = 1'b1; m_bad = 0; end
          end else begin
`ifdef PARKING_PIN_TIMEOUT_EN
            m_wait++;
            if (m_wait == PTO) begin m_st = M_IDLE; m_bad = 0; end
`endif
          end
        M_OPEN:
          if (sensor_exit) m_st = sensor_entrance ? M_BLOCK : M_IDLE;
        default:
          if (ok) begin m_st = M_IDLE; m_alarm = 1'b0; end
      endcase
      m_occ = nocc;
    end
  end

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic drive(input bit ent, input bit ext, input bit dep, input bit pv, input logic [7:0] pw);
    sensor_entrance = ent; sensor_exit = ext; sensor_depart = dep;
    pin_valid = pv; input_password = pw;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 8'h00);
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic admit();
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 1, PIN);   step();
    drive(0, 1, 0, 0, 8'h00); step();
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 8'h00);
    reset = 1'b1; step();
    n_vec++; if ({gate_open, gate_close, alarm_wrong_pin, alarm_block, lot_full} !== 5'b01000) begin
      n_err++; $display("FAIL reset_flags: got %b want 01000", {gate_open, gate_close, alarm_wrong_pin, alarm_block, lot_full}); end
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    reset = 1'b0;
  endtask

  task automatic test_admit();
    do_reset();
    drive(1, 0, 0, 0, 8'h00); step();
    n_vec++; if (gate_close !== 1'b1 || gate_open !== 1'b0) begin
      n_err++; $display("FAIL admit_wait: got open=%b close=%b want 0/1", gate_open, gate_close); end
    drive(0, 0, 0, 1, PIN); step();
    n_vec++; if (gate_open !== 1'b1 || gate_close !== 1'b0) begin
      n_err++; $display("FAIL admit_open: got open=%b close=%b want 1/0", gate_open, gate_close); end
    drive(0, 1, 0, 0, 8'h00); step();
    n_vec++; if (gate_open !== 1'b0 || occupancy !== 2'd1) begin
      n_err++; $display("FAIL admit_pass: got open=%b occ=%0d want 0/1", gate_open, occupancy); end
  endtask

  task automatic test_wrong_pin();
    do_reset();
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 1, 8'h00); step(); step();
    n_vec++; if (alarm_wrong_pin !== 1'b0) begin n_err++; $display("FAIL wrong2_alarm: got %b want 0", alarm_wrong_pin); end
    step();
    n_vec++; if (alarm_wrong_pin !== 1'b1) begin n_err++; $display("FAIL wrong3_alarm: got %b want 1", alarm_wrong_pin); end
    n_vec++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL wrong3_gate: got %b want 0", gate_open); end
    drive(0, 0, 0, 1, PIN); step();
    n_vec++; if (gate_open !== 1'b1 || alarm_wrong_pin !== 1'b0) begin
      n_err++; $display("FAIL wrong_recover: got open=%b alarm=%b want 1/0", gate_open, alarm_wrong_pin); end
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_tailgate();
    do_reset();
    drive(1, 1, 0, 0, 8'h00); step();
    n_vec++; if (alarm_block !== 1'b1 || gate_close !== 1'b1) begin
      n_err++; $display("FAIL tail_block: got blk=%b close=%b want 1/1", alarm_block, gate_close); end
    drive(0, 0, 0, 1, 8'h00); step(); step(); step();
    n_vec++; if (alarm_block !== 1'b1 || alarm_wrong_pin !== 1'b0) begin
      n_err++; $display("FAIL tail_wrongpin: got blk=%b alarm=%b want 1/0", alarm_block, alarm_wrong_pin); end
    drive(0, 0, 0, 1, PIN); step();
    n_vec++; if (alarm_block !== 1'b0 || gate_open !== 1'b0) begin
      n_err++; $display("FAIL tail_release: got blk=%b open=%b want 0/0", alarm_block, gate_open); end
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_capacity();
    do_reset();
    admit(); admit();
    n_vec++; if (occupancy !== 2'd2 || lot_full !== 1'b1) begin
      n_err++; $display("FAIL cap_full: got occ=%0d full=%b want 2/1", occupancy, lot_full); end
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 1, PIN);   step();
    n_vec++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL cap_refuse: got open=%b want 0", gate_open); end
    drive(0, 0, 1, 0, 8'h00); step();
    n_vec++; if (occupancy !== 2'd1 || lot_full !== 1'b0) begin
      n_err++; $display("FAIL cap_depart: got occ=%0d full=%b want 1/0", occupancy, lot_full); end
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 1, PIN);   step();
    drive(0, 1, 1, 0, 8'h00); step();
    n_vec++; if (occupancy !== 2'd1 || gate_open !== 1'b0) begin
      n_err++; $display("FAIL cap_incdec: got occ=%0d open=%b want 1/0", occupancy, gate_open); end
    drive(0, 0, 0, 0, 8'h00);
  endtask

`ifdef PARKING_PIN_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 0, 8'h00); repeat (PTO) step();
    drive(0, 0, 0, 1, PIN); step();
    n_vec++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL tmo_expire: got open=%b want 0", gate_open); end
    do_reset();
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 0, 8'h00); repeat (PTO - 1) step();
    drive(0, 0, 0, 1, PIN); step();
    n_vec++; if (gate_open !== 1'b1) begin n_err++; $display("FAIL tmo_edge: got open=%b want 1", gate_open); end
    do_reset();
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 0, 8'h00); repeat (10) step();
    drive(0, 0, 0, 1, 8'h00); step();
    drive(0, 0, 0, 0, 8'h00); repeat (PTO - 1) step();
    drive(0, 0, 0, 1, PIN); step();
    n_vec++; if (gate_open !== 1'b1) begin n_err++; $display("FAIL tmo_restart: got open=%b want 1", gate_open); end
    drive(0, 0, 0, 0, 8'h00);
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    admit();
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 0, 0, 1, PIN);   step();
    drive(0, 0, 0, 0, 8'h00);
    reset = 1'b1; step(); reset = 1'b0;
    n_vec++; if ({gate_open, gate_close, alarm_wrong_pin, alarm_block} !== 4'b0100 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL mid_reset: got flags=%b occ=%0d want 0100/0", {gate_open, gate_close, alarm_wrong_pin, alarm_block}, occupancy); end
    drive(0, 0, 1, 0, 8'h00); step();
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL occ_floor: got %0d want 0", occupancy); end
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0, ($urandom_range(0, 1) == 0) ? PIN : 8'($urandom));
      step();
      n_vec++;
      if (gate_open !== (m_st == M_OPEN) || gate_close !== (m_st != M_OPEN) ||
          alarm_block !== (m_st == M_BLOCK) || alarm_wrong_pin !== m_alarm ||
          occupancy !== 2'(m_occ) || lot_full !== (m_occ == CAP)) begin
        n_err++;
        $display("FAIL rand_%0d: got open=%b close=%b blk=%b alarm=%b occ=%0d full=%b want st=%0d alarm=%b occ=%0d",
                 i, gate_open, gate_close, alarm_block, alarm_wrong_pin, occupancy, lot_full, m_st, m_alarm, m_occ);
      end
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_admit();
    test_wrong_pin();
    test_tailgate();
    test_capacity();
`ifdef PARKING_PIN_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
